// File: rtl/axi_to_mem_r_beat_gen_if.sv
// Descriptor, memory read-data and R-beat channels of axi_to_mem_r_beat_gen.
// slave = beat generator view, master = the surrounding logic driving it.
interface axi_to_mem_r_beat_gen_if #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 4,
  parameter int UserWidth = 1
);
  localparam int BeatWidth = IdWidth + DataWidth + 3 + UserWidth;

  logic                 desc_valid_i;
  logic                 desc_ready_o;
  logic [IdWidth-1:0]   desc_id_i;
  logic [7:0]           desc_len_i;
  logic [UserWidth-1:0] desc_user_i;
  logic                 desc_err_i;

  logic                 mem_rvalid_i;
  logic                 mem_rready_o;
  logic [DataWidth-1:0] mem_rdata_i;
  logic                 mem_rerr_i;

  logic                 r_valid_o;
  logic                 r_ready_i;
  logic [BeatWidth-1:0] r_data_o;

  modport slave (
    input  desc_valid_i, desc_id_i, desc_len_i, desc_user_i, desc_err_i,
    input  mem_rvalid_i, mem_rdata_i, mem_rerr_i, r_ready_i,
    output desc_ready_o, mem_rready_o, r_valid_o, r_data_o
  );

  modport master (
    output desc_valid_i, desc_id_i, desc_len_i, desc_user_i, desc_err_i,
    output mem_rvalid_i, mem_rdata_i, mem_rerr_i, r_ready_i,
    input  desc_ready_o, mem_rready_o, r_valid_o, r_data_o
  );
endinterface

// File: rtl/axi_to_mem_r_beat_gen.sv
// Joins queued read-burst descriptors with the in-order memory data stream into R beats.
// Optional SLVERR beat counter: define AXI_TO_MEM_R_BEAT_ERRCNT_EN.
module axi_to_mem_r_beat_gen #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 4,
  parameter int UserWidth = 1,
  parameter int DescDepth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  axi_to_mem_r_beat_gen_if.slave bus,
  output logic busy_o
`ifdef AXI_TO_MEM_R_BEAT_ERRCNT_EN
  ,
  output logic [15:0] err_cnt_o,
  input  logic        err_cnt_clr_i
`endif
);
  localparam int AW = $clog2(DescDepth);
  localparam int BW = IdWidth + DataWidth + 3 + UserWidth;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [7:0]           len;
    logic [UserWidth-1:0] user;
    logic                 err;
  } desc_t;

  desc_t            fifo_q [DescDepth];
  desc_t            head, din;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rvld_q, rvld_d;
  logic [BW-1:0]    rdata_q, rdata_d;
  logic             full, head_vld, push, pop, out_free, load, last;
  logic [1:0]       resp;
  logic [DataWidth-1:0] beat_data;

  assign din      = '{id: bus.desc_id_i, len: bus.desc_len_i,
                      user: bus.desc_user_i, err: bus.desc_err_i};
  assign head     = fifo_q[rptr_q];
  assign full     = (fill_q == (AW+1)'(DescDepth));
  assign head_vld = (fill_q != '0);
  assign out_free = !rvld_q | bus.r_ready_i;
  assign last     = (cnt_q == head.len);
  assign load     = head_vld & !flush_i & !rst_i & out_free & (head.err | bus.mem_rvalid_i);
  assign push     = bus.desc_valid_i & bus.desc_ready_o;
  assign pop      = load & last;

  assign bus.desc_ready_o = !full & !flush_i & !rst_i;
  // Combinational from r_ready_i; the downstream spill register breaks this path.
  assign bus.mem_rready_o = head_vld & !head.err & !flush_i & !rst_i & out_free;
  assign bus.r_valid_o    = rvld_q;
  assign bus.r_data_o     = rdata_q;
  assign busy_o           = head_vld | rvld_q;

  // Error bursts never touch memory: zero data, SLVERR on every beat.
  assign beat_data = head.err ? '0 : bus.mem_rdata_i;
  assign resp      = (head.err | bus.mem_rerr_i) ? 2'b10 : 2'b00;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    rvld_d  = rvld_q;
    rdata_d = rdata_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    fill_d = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    if (load) begin
      rvld_d  = 1'b1;
      rdata_d = {head.id, beat_data, resp, last, head.user};
      cnt_d   = last ? 8'd0 : cnt_q + 8'd1;
    end else if (bus.r_ready_i) begin
      rvld_d  = 1'b0;
    end
    // A beat handshaken in the flush cycle has already left; just drop state.
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      rvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= din;
  end

`ifdef AXI_TO_MEM_R_BEAT_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;
  logic        err_hs;

  assign err_hs    = rvld_q & bus.r_ready_i & (rdata_q[UserWidth+2:UserWidth+1] == 2'b10);
  assign err_cnt_o = errcnt_q;

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_cnt_clr_i)                       errcnt_d = '0;
    else if (err_hs && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end
`endif
endmodule

// File: tb/tb_axi_to_mem_r_beat_gen.sv
// Scoreboard bench for axi_to_mem_r_beat_gen: expected beats queued at stimulus time,
// compared against every R beat the DUT presents.
module tb_axi_to_mem_r_beat_gen;
  localparam int DW = 32, IW = 4, UW = 1, DD = 4;
  localparam int BW = IW + DW + 3 + UW;

  typedef struct { logic [DW-1:0] d; logic e; } mbeat_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, busy;
  always #5 clk = ~clk;

  axi_to_mem_r_beat_gen_if #(.DataWidth(DW), .IdWidth(IW), .UserWidth(UW)) bus();

`ifdef AXI_TO_MEM_R_BEAT_ERRCNT_EN
  logic [15:0] err_cnt;
  logic        err_clr = 1'b0;
`endif

  axi_to_mem_r_beat_gen #(.DataWidth(DW), .IdWidth(IW), .UserWidth(UW), .DescDepth(DD)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus), .busy_o(busy)
`ifdef AXI_TO_MEM_R_BEAT_ERRCNT_EN
    , .err_cnt_o(err_cnt), .err_cnt_clr_i(err_clr)
`endif
  );

  int             n_chk = 0, n_err = 0, rx_cnt = 0;
  logic [BW-1:0]  expq[$];
  mbeat_t         memq[$];
  bit             mem_en = 1'b1, mem_junk = 1'b0, mem_hs, desc_hs;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(logic [IW-1:0] id, logic [DW-1:0] d,
                                         logic [1:0] resp, logic last, logic [UW-1:0] u);
    return {id, d, resp, last, u};
  endfunction

  // Every beat on the R port must match the scoreboard head, stalled or not.
  always @(negedge clk) begin
    mem_hs  = bus.mem_rvalid_i & bus.mem_rready_o;
    desc_hs = bus.desc_valid_i & bus.desc_ready_o;
    if (!rst && bus.r_valid_o) begin
      if (expq.size() == 0) chk("spurious_beat", 64'(bus.r_data_o), 64'(0));
      else begin
        chk("beat", 64'(bus.r_data_o), 64'(expq[0]));
        if (bus.r_ready_i) begin
          void'(expq.pop_front());
          rx_cnt++;
        end
      end
    end
  end

  task automatic drive_mem();
    if (mem_en && memq.size() > 0) begin
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = memq[0].d; bus.mem_rerr_i = memq[0].e;
    end else if (mem_junk) begin
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF; bus.mem_rerr_i = 1'b0;
    end else begin
      bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_rerr_i = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mem_hs && memq.size() > 0) void'(memq.pop_front());
    drive_mem();
  endtask

  task automatic send_desc(input logic [IW-1:0] id, input logic [7:0] len, input logic [UW-1:0] user,
                           input logic err, input logic [DW-1:0] base, input logic rerr);
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      if (err) expq.push_back(pack(id, '0, 2'b10, i == int'(len), user));
      else begin
        memq.push_back('{base + DW'(i), rerr});
        expq.push_back(pack(id, base + DW'(i), rerr ? 2'b10 : 2'b00, i == int'(len), user));
      end
    end
    drive_mem();
    bus.desc_id_i = id; bus.desc_len_i = len; bus.desc_user_i = user; bus.desc_err_i = err;
    bus.desc_valid_i = 1'b1;
    t = 0;
    do begin step(); t++; end while (!desc_hs && t < 50);
    if (!desc_hs) chk("desc_timeout", 64'(0), 64'(1));
    bus.desc_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((expq.size() != 0 || busy) && t < 600) begin step(); t++; end
    chk({tag, "_drain"}, 64'(expq.size()), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_rx(input int target);
    int t = 0;
    while (rx_cnt < target && t < 100) begin step(); t++; end
    chk("rx_wait", 64'(rx_cnt >= target), 64'(1));
  endtask

  initial begin
    int r0, t;
    bus.desc_valid_i = 1'b1; bus.desc_id_i = '0; bus.desc_len_i = '0;
    bus.desc_user_i = '0; bus.desc_err_i = 1'b0; bus.r_ready_i = 1'b1;
    drive_mem();
    repeat (3) step();
    chk("rst_rvalid", 64'(bus.r_valid_o), 64'(0));
    chk("rst_rdata", 64'(bus.r_data_o), 64'(0));
    chk("rst_dready", 64'(bus.desc_ready_o), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    bus.desc_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_dready", 64'(bus.desc_ready_o), 64'(1));

    // Basic burst plus two-cycle first-beat latency
    send_desc(4'd3, 8'd3, 1'b1, 1'b0, 32'hA0, 1'b0);
    chk("t1_lat_n1", 64'(bus.r_valid_o), 64'(0));
    step();
    chk("t1_lat_n2", 64'(bus.r_valid_o), 64'(1));
    wait_drain("t1");

    // Locally generated error burst must never handshake memory
    mem_junk = 1'b1;
    drive_mem();
    send_desc(4'd5, 8'd1, 1'b0, 1'b1, '0, 1'b0);
    t = 0;
    while (expq.size() != 0 && t < 20) begin
      chk("t2_mem_rready", 64'(bus.mem_rready_o), 64'(0));
      step(); t++;
    end
    mem_junk = 1'b0;
    drive_mem();
    wait_drain("t2");

    // Fill FIFO, then hold the output beat under backpressure
    mem_en = 1'b0; bus.r_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_desc(IW'(8 + i), 8'd0, UW'(i), 1'b0, 32'hC0 + DW'(i * 16), 1'b0);
    chk("t3_full", 64'(bus.desc_ready_o), 64'(0));
    mem_en = 1'b1;
    drive_mem();
    repeat (5) step();
    chk("t3_held", 64'(bus.r_valid_o), 64'(1));
    bus.r_ready_i = 1'b1;
    wait_drain("t3");

    // Long burst with R backpressure and a memory stall
    r0 = rx_cnt;
    send_desc(4'd2, 8'd7, 1'b0, 1'b0, 32'h40, 1'b0);
    wait_rx(r0 + 3);
    bus.r_ready_i = 1'b0;
    repeat (5) step();
    mem_en = 1'b0; bus.r_ready_i = 1'b1;
    drive_mem();
    repeat (3) step();
    mem_en = 1'b1;
    drive_mem();
    wait_drain("t4");
    chk("t4_count", 64'(rx_cnt - r0), 64'(8));

    // Maximum length burst
    r0 = rx_cnt;
    send_desc(4'd1, 8'd255, 1'b1, 1'b0, 32'h1000, 1'b1);
    wait_drain("t_len255");
    chk("t_len255_count", 64'(rx_cnt - r0), 64'(256));

    // Flush mid-burst with two bursts queued
    r0 = rx_cnt;
    send_desc(4'd1, 8'd3, 1'b0, 1'b0, 32'h10, 1'b0);
    send_desc(4'd2, 8'd3, 1'b1, 1'b0, 32'h20, 1'b0);
    wait_rx(r0 + 2);
    flush = 1'b1;
    #1;
    chk("t5_flush_dready", 64'(bus.desc_ready_o), 64'(0));
    chk("t5_flush_mrready", 64'(bus.mem_rready_o), 64'(0));
    step();
    flush = 1'b0;
    expq.delete(); memq.delete();
    drive_mem();
    chk("t5_rvalid", 64'(bus.r_valid_o), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    send_desc(4'd6, 8'd0, 1'b1, 1'b0, 32'h77, 1'b0);
    wait_drain("t5");

    // Reset mid-burst also clears the output data
    bus.r_ready_i = 1'b0;
    send_desc(4'd4, 8'd3, 1'b0, 1'b0, 32'h55, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expq.delete(); memq.delete();
    drive_mem();
    chk("t6_rvalid", 64'(bus.r_valid_o), 64'(0));
    chk("t6_rdata", 64'(bus.r_data_o), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    bus.r_ready_i = 1'b1;

`ifdef AXI_TO_MEM_R_BEAT_ERRCNT_EN
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ec_clr", 64'(err_cnt), 64'(0));
    send_desc(4'd7, 8'd2, 1'b0, 1'b0, 32'h90, 1'b1);
    wait_drain("ec");
    chk("ec_three", 64'(err_cnt), 64'(3));
    bus.r_ready_i = 1'b0;
    send_desc(4'd7, 8'd0, 1'b0, 1'b0, 32'h99, 1'b1);
    t = 0;
    while (!bus.r_valid_o && t < 20) begin step(); t++; end
    bus.r_ready_i = 1'b1; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ec_clr_wins", 64'(err_cnt), 64'(0));
    wait_drain("ec2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
